inst_encoder: RTL

//  Inverse of the immediate extractor: packs opcode/funct/register fields plus a
//  32-bit immediate into a legal RV32I instruction word. Used by the boot-time

---
 rtl/inst_encoder_pkg.sv | 67 ++++++
 rtl/imm_range_check.sv | 39 +++
 rtl/inst_encoder.sv | 108 ++++++++++
 3 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared RV32I encoding definitions: format codes, opcodes,
// the S1 bundle and the instruction word assembler.
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_ISH = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4,
    FMT_U   = 3'd5,
    FMT_J   = 3'd6,
    FMT_RSV = 3'd7
  } fmt_e;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        legal;
  } s1_t;

  function automatic logic [31:0] assemble(s1_t s);
    logic [31:0] w;
    w = '0;
    unique case (s.fmt)
      FMT_R:
        w = {s.f7, s.rs2, s.rs1, s.f3, s.rd, s.op};
      FMT_I:
        w = {s.imm[11:0], s.rs1, s.f3, s.rd, s.op};
      FMT_ISH:
        w = {s.f7, s.imm[4:0], s.rs1, s.f3, s.rd, s.op};
      FMT_S:
        w = {s.imm[11:5], s.rs2, s.rs1, s.f3,
             s.imm[4:0], s.op};
      FMT_B:
        w = {s.imm[12], s.imm[10:5], s.rs2, s.rs1, s.f3,
             s.imm[4:1], s.imm[11], s.op};
      FMT_U:
        w = {s.imm[31:12], s.rd, s.op};
      FMT_J:
        w = {s.imm[20], s.imm[10:1], s.imm[11],
             s.imm[19:12], s.rd, s.op};
      FMT_RSV:
        w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imm_range_check.sv
// Decides whether an immediate (and shift funct7) is
// representable in the requested instruction format.
module imm_range_check
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [31:0] imm_i,
  input  logic [6:0]  funct7_i,
  output logic        legal_o
);

  fmt_e fmt;
  assign fmt = fmt_e'(fmt_i);

  always_comb begin
    legal_o = 1'b0;
    unique case (fmt)
      FMT_R:
        legal_o = 1'b1;
      FMT_I, FMT_S:
        legal_o = imm_i[31:12] == {20{imm_i[11]}};
      FMT_ISH:
        legal_o = (imm_i[31:5] == '0) &&
                  ((funct7_i == 7'h00) ||
                   (funct7_i == 7'h20));
      FMT_B:
        legal_o = (imm_i[31:13] == {19{imm_i[12]}}) &&
                  !imm_i[0];
      FMT_U:
        legal_o = imm_i[11:0] == '0;
      FMT_J:
        legal_o = (imm_i[31:21] == {11{imm_i[20]}}) &&
                  !imm_i[0];
      FMT_RSV:
        legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with
// immediate range check and IMEM address assignment.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0] NOP_INST  = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              addr_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  logic              legal;
  s1_t               s1_d;
  s1_t               s1_q;
  logic              s1_valid_q;
  logic              s2_adv;
  logic              out_hs;
  logic [31:0]       word_d;
  logic              out_valid_q;
  logic [31:0]       out_inst_q;
  logic              out_err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        err_cnt_q;

  imm_range_check u_chk (
    .fmt_i    (in_fmt),
    .imm_i    (in_imm),
    .funct7_i (in_funct7),
    .legal_o  (legal)
  );

  always_comb begin
    s1_d       = '0;
    s1_d.fmt   = fmt_e'(in_fmt);
    s1_d.op    = in_opcode;
    s1_d.f3    = in_funct3;
    s1_d.f7    = in_funct7;
    s1_d.rd    = in_rd;
    s1_d.rs1   = in_rs1;
    s1_d.rs2   = in_rs2;
    s1_d.imm   = in_imm;
    s1_d.legal = legal;
  end

  assign word_d   = s1_q.legal ? assemble(s1_q)
                               : NOP_INST;
  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign out_hs   = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_err_q   <= 1'b0;
      addr_q      <= BASE_ADDR;
      err_cnt_q   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_inst_q <= word_d;
          out_err_q  <= !s1_q.legal;
        end
      end
      // a clear wins over the increment; the word
      // leaving this cycle already carries the old address
      if (addr_clr)
        addr_q <= BASE_ADDR;
      else if (out_hs)
        addr_q <= addr_q + ADDR_W'(4);
      if (out_hs && out_err_q && (err_cnt_q != 8'hff))
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign out_addr  = addr_q;
  assign err_cnt   = err_cnt_q;

endmodule
